// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage for the radix-2^2 SDF FFT: accepts bit-reversed frames and
// replays each one in natural order from a ping-pong buffer, back-to-back at full rate.
module fft_bitrev_reorder #(
   parameter int DATA_WIDTH = 16,
   parameter int N_POINTS   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] in_re,
   input  logic [DATA_WIDTH-1:0] in_im,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_re,
   output logic [DATA_WIDTH-1:0] out_im,
   output logic                  out_first,
   output logic                  out_last
);

   localparam int LOG2N = $clog2(N_POINTS);
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

   typedef enum logic {
      IDLE,
      READ
   } state_t;

   state_t state, state_nxt;

   logic [LOG2N-1:0]        wr_cnt;
   logic [LOG2N-1:0]        rd_cnt, rd_cnt_nxt;
   logic                    wr_bank;
   logic                    rd_bank, rd_bank_nxt;
   logic                    frame_done;
   logic                    rd_en;
   logic [2*DATA_WIDTH-1:0] rd_word;

   // Both banks share one array; the bank select is the address MSB.
   logic [2*DATA_WIDTH-1:0] mem [0:2*N_POINTS-1];

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = k[LOG2N-1-i];
      end
      return r;
   endfunction

   assign frame_done = en && (wr_cnt == LAST_IDX);
   assign rd_word    = mem[{rd_bank, rd_cnt}];

   // Write side: scatter samples to their natural-order slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (en) begin
         wr_cnt <= wr_cnt + 1'b1;
         if (frame_done) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en && !rst) begin
         mem[{wr_bank, bitrev(wr_cnt)}] <= {in_re, in_im};
      end
   end

   // Read FSM: a completed frame hands over its bank; a frame that completes on the
   // final read edge chains straight into the next readout.
   always_comb begin
      state_nxt   = state;
      rd_cnt_nxt  = rd_cnt;
      rd_bank_nxt = rd_bank;
      rd_en       = 1'b0;
      case (state)
         IDLE: begin
            if (frame_done) begin
               state_nxt   = READ;
               rd_cnt_nxt  = '0;
               rd_bank_nxt = wr_bank;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (rd_cnt == LAST_IDX) begin
               rd_cnt_nxt = '0;
               if (frame_done) begin
                  rd_bank_nxt = wr_bank;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               rd_cnt_nxt = rd_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_cnt    <= '0;
         rd_bank   <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         state     <= state_nxt;
         rd_cnt    <= rd_cnt_nxt;
         rd_bank   <= rd_bank_nxt;
         out_valid <= rd_en;
         out_first <= rd_en && (rd_cnt == '0);
         out_last  <= rd_en && (rd_cnt == LAST_IDX);
         if (rd_en) begin
            {out_re, out_im} <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: table-driven single frame plus scoreboarded
// multi-frame, gapped, reset and N=64 sequences.
module tb_fft_bitrev_reorder;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic        first;
      logic        last;
   } exp_t;

   typedef struct {
      logic [15:0] in_re;
      logic [15:0] in_im;
      logic [15:0] exp_re;
      logic [15:0] exp_im;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en16 = 1'b0, en64 = 1'b0;
   logic [15:0] re16 = '0, im16 = '0, re64 = '0, im64 = '0;
   logic        v16, f16, l16, v64, f64, l64;
   logic [15:0] r16, i16, r64, i64;

   int          checks = 0;
   int          errors = 0;
   logic        mon_on = 1'b0;
   exp_t        q16[$];
   exp_t        q64[$];
   int          run16 = 0, max16 = 0;
   int          idx64 = 0;
   logic [15:0] obs64 [6];
   logic [15:0] last64 = '0;
   vec_t        tbl [16];

   always #5 clk = ~clk;

   fft_bitrev_reorder #(.DATA_WIDTH(16), .N_POINTS(16)) dut16 (
      .clk(clk), .rst(rst), .en(en16), .in_re(re16), .in_im(im16),
      .out_valid(v16), .out_re(r16), .out_im(i16), .out_first(f16), .out_last(l16)
   );

   fft_bitrev_reorder #(.DATA_WIDTH(16), .N_POINTS(64)) dut64 (
      .clk(clk), .rst(rst), .en(en64), .in_re(re64), .in_im(im64),
      .out_valid(v64), .out_re(r64), .out_im(i64), .out_first(f64), .out_last(l64)
   );

   function automatic int brev(input int k, input int bits);
      int r = 0;
      for (int i = 0; i < bits; i++) begin
         if (k[i]) r |= 1 << (bits - 1 - i);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_frame16(input logic [15:0] base_re, input logic [15:0] base_im);
      exp_t e;
      for (int j = 0; j < 16; j++) begin
         e.re    = base_re + 16'(brev(j, 4));
         e.im    = base_im + 16'(brev(j, 4));
         e.first = (j == 0);
         e.last  = (j == 15);
         q16.push_back(e);
      end
   endtask

   task automatic cyc16(input logic e, input logic [15:0] r, input logic [15:0] i);
      en16 = e;
      re16 = r;
      im16 = i;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      en16 = 1'b0;
      en64 = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain16(input string name);
      for (int c = 0; c < 200 && q16.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      chk({name, "_drain"}, q16.size(), 0);
      @(posedge clk);
      #1;
      chk({name, "_valid_after"}, v16, 1'b0);
   endtask

   // Scoreboards: compare every presented sample against the queued expectation.
   always @(negedge clk) begin
      if (mon_on) begin
         if (v16 === 1'b1) begin
            if (q16.size() == 0) begin
               chk("unexpected_valid16", {16'h0, r16}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q16.pop_front();
               chk("re16", r16, e.re);
               chk("im16", i16, e.im);
               chk("first16", f16, e.first);
               chk("last16", l16, e.last);
            end
            run16++;
            if (run16 > max16) max16 = run16;
         end else begin
            run16 = 0;
            chk("idle_flags16", {v16, f16, l16}, 3'b000);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         if (v64 === 1'b1) begin
            if (q64.size() == 0) begin
               chk("unexpected_valid64", {16'h0, r64}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q64.pop_front();
               chk("re64", r64, e.re);
               chk("im64", i64, e.im);
               chk("first64", f64, e.first);
               chk("last64", l64, e.last);
            end
            if (idx64 < 6) obs64[idx64] = r64;
            if (l64) last64 = r64;
            idx64++;
         end else begin
            chk("idle_flags64", {v64, f64, l64}, 3'b000);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int perm[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      int found;
      exp_t e;
      for (int k = 0; k < 16; k++) begin
         tbl[k].in_re  = 16'(k);
         tbl[k].in_im  = 16'h0100 + 16'(k);
         tbl[k].exp_re = 16'(perm[k]);
         tbl[k].exp_im = 16'h0100 + 16'(perm[k]);
      end

      // Reset state
      rst = 1'b1;
      idle(3);
      chk("rst_valid16", v16, 1'b0);
      chk("rst_re16", r16, 16'h0);
      chk("rst_im16", i16, 16'h0);
      chk("rst_flags16", {f16, l16}, 2'b00);
      chk("rst_valid64", v64, 1'b0);
      chk("rst_data64", {r64, i64}, 32'h0);
      rst = 1'b0;
      mon_on = 1'b1;
      idle(2);

      // Single frame from the table, with latency check around edge E
      for (int k = 0; k < 16; k++) begin
         e.re    = tbl[k].exp_re;
         e.im    = tbl[k].exp_im;
         e.first = (k == 0);
         e.last  = (k == 15);
         q16.push_back(e);
         cyc16(1'b1, tbl[k].in_re, tbl[k].in_im);
      end
      en16 = 1'b0;
      chk("lat_before_first", v16, 1'b0);
      cyc16(1'b0, 16'h0, 16'h0);
      chk("lat_first_valid", {v16, f16}, 2'b11);
      chk("lat_first_re", r16, 16'h0);
      drain16("single");

      // Three back-to-back frames: output must stay high for 48 cycles
      max16 = 0;
      for (int f = 0; f < 3; f++) push_frame16(16'h0, 16'h0100);
      for (int n = 0; n < 48; n++) cyc16(1'b1, 16'(n % 16), 16'h0100 + 16'(n % 16));
      en16 = 1'b0;
      drain16("b2b");
      chk("b2b_run", max16, 48);

      // Alternating enable: idle-cycle data must not be stored
      max16 = 0;
      push_frame16(16'h0, 16'h0100);
      for (int n = 0; n < 32; n++) begin
         if (n % 2 == 0) cyc16(1'b1, 16'(n / 2), 16'h0100 + 16'(n / 2));
         else            cyc16(1'b0, 16'hDEAD, 16'hBEEF);
      end
      chk("alt_first_timing", {v16, f16}, 2'b11);
      drain16("alt");
      chk("alt_run", max16, 16);

      // Partial frame discarded by reset; reset wins over en on the same edge
      for (int k = 0; k < 7; k++) cyc16(1'b1, 16'(k), 16'h0100 + 16'(k));
      rst = 1'b1;
      cyc16(1'b1, 16'hBEEF, 16'hBEEF);
      rst = 1'b0;
      push_frame16(16'h1000, 16'h3000);
      for (int k = 0; k < 16; k++) cyc16(1'b1, 16'h1000 + 16'(k), 16'h3000 + 16'(k));
      en16 = 1'b0;
      drain16("partial");

      // Reset while output index 5 is presented
      push_frame16(16'h2000, 16'h2100);
      for (int k = 0; k < 16; k++) cyc16(1'b1, 16'h2000 + 16'(k), 16'h2100 + 16'(k));
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
         cyc16(1'b0, 16'h0, 16'h0);
         if (v16 === 1'b1 && r16 === 16'h200A) found = 1;
      end
      chk("idx5_seen", found, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rdrst_valid", v16, 1'b0);
      chk("rdrst_data", {r16, i16}, 32'h0);
      chk("rdrst_flags", {f16, l16}, 2'b00);
      q16.delete();
      rst = 1'b0;
      idle(30);
      chk("rdrst_quiet", v16, 1'b0);

      // N_POINTS = 64 ramp
      for (int j = 0; j < 64; j++) begin
         e.re    = 16'(brev(j, 6));
         e.im    = 16'h0400 + 16'(brev(j, 6));
         e.first = (j == 0);
         e.last  = (j == 63);
         q64.push_back(e);
      end
      idx64 = 0;
      for (int k = 0; k < 64; k++) begin
         en64 = 1'b1;
         re64 = 16'(k);
         im64 = 16'h0400 + 16'(k);
         @(posedge clk);
         #1;
      end
      en64 = 1'b0;
      for (int c = 0; c < 200 && q64.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      chk("n64_drain", q64.size(), 0);
      chk("n64_seq0", obs64[0], 16'd0);
      chk("n64_seq1", obs64[1], 16'd32);
      chk("n64_seq2", obs64[2], 16'd16);
      chk("n64_seq3", obs64[3], 16'd48);
      chk("n64_seq4", obs64[4], 16'd8);
      chk("n64_seq5", obs64[5], 16'd40);
      chk("n64_last", last64, 16'd63);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
